// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
// Fetch initiator for a 16x8 program ROM. Drives the ROM address from the
// program counter, holds rom_read_en for SETTLE_CYCLES cycles, captures the
// returned byte into the instruction register and offers it to the control
// unit as opcode/operand.
//
// Handshake: instr_valid is high while an instruction is held. The control
// unit consumes it by raising instr_ack for one cycle while instr_valid=1.
// opcode/operand stay stable from the rise of instr_valid until the ack edge.
// jump_en/jump_addr are meaningful only together with that ack.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start                 begin fetching from pc (sampled only in IDLE)
//   rom_address[3:0]      ROM address, always equal to pc
//   rom_read_en           ROM output enable, high only while fetching
//   rom_data[7:0]         ROM data bus (may float when rom_read_en=0)
//   instr_valid           opcode/operand hold a fetched instruction
//   opcode[3:0]           IR[7:4]
//   operand[3:0]          IR[3:0]
//   instr_ack             control unit consumes the instruction
//   jump_en, jump_addr    with instr_ack, load pc from jump_addr
//   pc[3:0]               program counter
//   halted                halt opcode acknowledged, fetching stopped
//   o_dbg_state[1:0]      FSM state (0 IDLE, 1 FETCH, 2 VALID, 3 HALTED)
module instr_fetch_unit #(
  parameter int          SETTLE_CYCLES = 1,
  parameter logic [3:0]  HALT_OPCODE   = 4'hF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [3:0] rom_address,
  output logic       rom_read_en,
  input  logic [7:0] rom_data,
  output logic       instr_valid,
  output logic [3:0] opcode,
  output logic [3:0] operand,
  input  logic       instr_ack,
  input  logic       jump_en,
  input  logic [3:0] jump_addr,
  output logic [3:0] pc,
  output logic       halted,
  output logic [1:0] o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_VALID  = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  // Counter value on the last settle cycle; 3 bits cover the legal 1..7 range.
  localparam logic [2:0] LP_LAST = 3'(SETTLE_CYCLES - 1);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_pc;
  logic [7:0] r_ir;
  logic [2:0] r_cnt;
  logic       w_settled;
  logic       w_is_halt;

  assign w_settled = (r_cnt == LP_LAST);
  assign w_is_halt = (r_ir[7:4] == HALT_OPCODE);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_FETCH;
      S_FETCH:  if (w_settled) w_next = S_VALID;
      S_VALID:  if (instr_ack) w_next = w_is_halt ? S_HALTED : S_FETCH;
      S_HALTED: w_next = S_HALTED;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Datapath. pc is incremented at capture time, so a plain ack simply
  // starts the next fetch; a jump overrides it. A halt ack leaves pc alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc  <= 4'h0;
      r_ir  <= 8'h00;
      r_cnt <= 3'd0;
    end else begin
      case (r_state)
        S_FETCH: begin
          r_cnt <= r_cnt + 3'd1;
          if (w_settled) begin
            r_ir  <= rom_data;
            r_pc  <= r_pc + 4'd1;
            r_cnt <= 3'd0;
          end
        end
        S_VALID: begin
          r_cnt <= 3'd0;
          if (instr_ack && !w_is_halt && jump_en) r_pc <= jump_addr;
        end
        default: r_cnt <= 3'd0;
      endcase
    end
  end

  assign rom_address = r_pc;
  assign pc          = r_pc;
  assign opcode      = r_ir[7:4];
  assign operand     = r_ir[3:0];
  assign rom_read_en = (r_state == S_FETCH);
  assign instr_valid = (r_state == S_VALID);
  assign halted      = (r_state == S_HALTED);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit. Two instances: u_dut (SETTLE_CYCLES=1) for
// the functional scenarios and randomized runs, u_dut3 (SETTLE_CYCLES=3) for
// the asynchronous reset during a fetch. Each instance has its own ROM model
// that floats the bus when read_en is low.
module tb_instr_fetch_unit;

  localparam int S1 = 1;
  localparam int S3 = 3;
  localparam int WAIT_LIMIT = 40;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n  = 1'b0;
  logic       rst3_n = 1'b0;
  logic       start = 1'b0;
  logic       instr_ack = 1'b0;
  logic       jump_en = 1'b0;
  logic [3:0] jump_addr = 4'h0;

  logic [3:0] rom_address, rom_address3;
  logic       rom_read_en, rom_read_en3;
  logic [7:0] rom_data, rom_data3;
  logic       instr_valid, instr_valid3;
  logic [3:0] opcode, opcode3, operand, operand3, pc, pc3;
  logic       halted, halted3;
  logic [1:0] dbg_state, dbg_state3;

  logic [7:0] rom [16];
  logic [7:0] rom3 [16];

  assign rom_data  = rom_read_en  ? rom[rom_address]   : 8'hzz;
  assign rom_data3 = rom_read_en3 ? rom3[rom_address3] : 8'hzz;

  instr_fetch_unit #(.SETTLE_CYCLES(S1), .HALT_OPCODE(4'hF)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .rom_address(rom_address), .rom_read_en(rom_read_en), .rom_data(rom_data),
    .instr_valid(instr_valid), .opcode(opcode), .operand(operand),
    .instr_ack(instr_ack), .jump_en(jump_en), .jump_addr(jump_addr),
    .pc(pc), .halted(halted), .o_dbg_state(dbg_state)
  );

  instr_fetch_unit #(.SETTLE_CYCLES(S3), .HALT_OPCODE(4'hF)) u_dut3 (
    .clk(clk), .rst_n(rst3_n), .start(start),
    .rom_address(rom_address3), .rom_read_en(rom_read_en3), .rom_data(rom_data3),
    .instr_valid(instr_valid3), .opcode(opcode3), .operand(operand3),
    .instr_ack(instr_ack), .jump_en(jump_en), .jump_addr(jump_addr),
    .pc(pc3), .halted(halted3), .o_dbg_state(dbg_state3)
  );

  int n_vec = 0;
  int n_err = 0;

  // Scoreboard: expected instruction bytes in order of delivery.
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;
  logic [3:0] model_pc;

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start = 0; instr_ack = 0; jump_en = 0; jump_addr = 0;
    rst_n = 0;
    step(); step();
    rst_n = 1;
    step();
  endtask

  task automatic load_test_rom();
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    rom[0] = 8'h10; rom[1] = 8'h2A; rom[2] = 8'hA0;
    rom[3] = 8'h40; rom[4] = 8'h10; rom[5] = 8'hF0;
  endtask

  task automatic pulse_start();
    start = 1; step(); start = 0;
  endtask

  task automatic do_ack(input logic jmp, input logic [3:0] addr);
    instr_ack = 1; jump_en = jmp; jump_addr = addr;
    step();
    instr_ack = 0; jump_en = 0;
  endtask

  // Steps until instr_valid or the budget runs out; returns cycles waited.
  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (!instr_valid && cycles < WAIT_LIMIT) begin
      step();
      cycles++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 0;
    #2;
    n_vec++;
    if ({instr_valid, rom_read_en, halted, opcode, operand, rom_address, pc} !== 19'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b re=%b h=%b op=%h opd=%h a=%h pc=%h, want all 0",
               instr_valid, rom_read_en, halted, opcode, operand, rom_address, pc);
    end
    step();
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_vec++;
      if (rom_read_en !== 0 || instr_valid !== 0 || pc !== 4'h0 || dbg_state !== 2'd0) begin
        n_err++;
        $display("FAIL reset_idle: cycle %0d re=%b v=%b pc=%h st=%0d, want 0 0 0 IDLE",
                 i, rom_read_en, instr_valid, pc, dbg_state);
      end
    end
  endtask

  task automatic test_free_run();
    int cyc;
    load_test_rom();
    do_reset();
    model_pc = 4'h0;
    exp_q.delete();
    // Walk the image from pc 0 until a halt byte is queued.
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(rom[model_pc]);
      if (rom[model_pc][7:4] == 4'hF) break;
      model_pc = model_pc + 4'd1;
    end
    pulse_start();
    while (exp_q.size() > 0) begin
      exp_b = exp_q.pop_front();
      wait_valid(cyc);
      n_vec++;
      if (!instr_valid || cyc !== S1 || {opcode, operand} !== exp_b || rom_read_en !== 0) begin
        n_err++;
        $display("FAIL free_run_instr: got v=%b after %0d cyc instr=%h re=%b, want v=1 after %0d instr=%h re=0",
                 instr_valid, cyc, {opcode, operand}, rom_read_en, S1, exp_b);
      end
      do_ack(0, 4'h0);
    end
    n_vec++;
    if (halted !== 1 || pc !== 4'h6 || instr_valid !== 0 || rom_read_en !== 0) begin
      n_err++;
      $display("FAIL free_run_halt: h=%b pc=%h v=%b re=%b, want h=1 pc=6 v=0 re=0",
               halted, pc, instr_valid, rom_read_en);
    end
    start = 1; instr_ack = 1; jump_en = 1; jump_addr = 4'h2;
    for (int i = 0; i < 4; i++) begin
      step();
      n_vec++;
      if (halted !== 1 || pc !== 4'h6 || instr_valid !== 0 || rom_read_en !== 0) begin
        n_err++;
        $display("FAIL halt_sticky: cycle %0d h=%b pc=%h v=%b re=%b, want 1 6 0 0",
                 i, halted, pc, instr_valid, rom_read_en);
      end
    end
    start = 0; instr_ack = 0; jump_en = 0;
  endtask

  task automatic test_backpressure();
    int cyc;
    load_test_rom();
    do_reset();
    pulse_start();
    wait_valid(cyc);
    // Jump request without ack must be ignored, as must start.
    jump_en = 1; jump_addr = 4'h9; start = 1;
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (instr_valid !== 1 || opcode !== 4'h1 || operand !== 4'h0 || pc !== 4'h1 || rom_read_en !== 0) begin
        n_err++;
        $display("FAIL backpressure_hold: cycle %0d v=%b op=%h opd=%h pc=%h re=%b, want 1 1 0 1 0",
                 i, instr_valid, opcode, operand, pc, rom_read_en);
      end
      step();
    end
    jump_en = 0; start = 0;
    do_ack(0, 4'h0);
    n_vec++;
    if (rom_read_en !== 1 || rom_address !== 4'h1) begin
      n_err++;
      $display("FAIL backpressure_refetch: re=%b addr=%h, want re=1 addr=1", rom_read_en, rom_address);
    end
    wait_valid(cyc);
    n_vec++;
    if (!instr_valid || {opcode, operand} !== 8'h2A || pc !== 4'h2) begin
      n_err++;
      $display("FAIL backpressure_next: v=%b instr=%h pc=%h, want v=1 instr=2a pc=2",
               instr_valid, {opcode, operand}, pc);
    end
  endtask

  // Continues from the state test_backpressure leaves (0x2A held, pc=2).
  task automatic test_jump();
    int cyc;
    do_ack(0, 4'h0);
    wait_valid(cyc);
    n_vec++;
    if (!instr_valid || {opcode, operand} !== 8'hA0 || pc !== 4'h3) begin
      n_err++;
      $display("FAIL jump_pre: v=%b instr=%h pc=%h, want v=1 instr=a0 pc=3",
               instr_valid, {opcode, operand}, pc);
    end
    do_ack(1, 4'h0);
    n_vec++;
    if (rom_read_en !== 1 || rom_address !== 4'h0) begin
      n_err++;
      $display("FAIL jump_addr: re=%b addr=%h, want re=1 addr=0", rom_read_en, rom_address);
    end
    wait_valid(cyc);
    n_vec++;
    if (!instr_valid || {opcode, operand} !== 8'h10 || pc !== 4'h1) begin
      n_err++;
      $display("FAIL jump_target: v=%b instr=%h pc=%h, want v=1 instr=10 pc=1",
               instr_valid, {opcode, operand}, pc);
    end
  endtask

  // Continues from test_jump (0x10 held, pc=1).
  task automatic test_wrap();
    int cyc;
    do_ack(1, 4'hF);
    n_vec++;
    if (rom_read_en !== 1 || rom_address !== 4'hF) begin
      n_err++;
      $display("FAIL wrap_addr: re=%b addr=%h, want re=1 addr=f", rom_read_en, rom_address);
    end
    wait_valid(cyc);
    n_vec++;
    if (!instr_valid || {opcode, operand} !== 8'h00 || pc !== 4'h0) begin
      n_err++;
      $display("FAIL wrap_pc: v=%b instr=%h pc=%h, want v=1 instr=00 pc=0",
               instr_valid, {opcode, operand}, pc);
    end
    do_ack(0, 4'h0);
    wait_valid(cyc);
    n_vec++;
    if (!instr_valid || {opcode, operand} !== 8'h10 || pc !== 4'h1) begin
      n_err++;
      $display("FAIL wrap_next: v=%b instr=%h pc=%h, want v=1 instr=10 pc=1",
               instr_valid, {opcode, operand}, pc);
    end
  endtask

  // Random ROM images, random backpressure and jumps, checked against a
  // transaction-level model: instruction = rom[pc], then pc advances or jumps.
  task automatic test_random();
    int cyc, hold;
    logic jmp;
    logic [3:0] ja;
    for (int run = 0; run < 4; run++) begin
      for (int i = 0; i < 16; i++) rom[i] = 8'($urandom_range(0, 255));
      do_reset();
      model_pc = 4'h0;
      pulse_start();
      for (int n = 0; n < 30; n++) begin
        exp_q.push_back(rom[model_pc]);
        exp_b = exp_q.pop_front();
        wait_valid(cyc);
        n_vec++;
        if (!instr_valid || cyc !== S1 || {opcode, operand} !== exp_b ||
            pc !== model_pc + 4'd1 || rom_read_en !== 0) begin
          n_err++;
          $display("FAIL random_instr: run %0d n %0d v=%b cyc=%0d instr=%h pc=%h re=%b, want v=1 cyc=%0d instr=%h pc=%h re=0",
                   run, n, instr_valid, cyc, {opcode, operand}, pc, rom_read_en,
                   S1, exp_b, model_pc + 4'd1);
        end
        hold = $urandom_range(0, 3);
        for (int h = 0; h < hold; h++) begin
          jump_en = 1'($urandom_range(0, 1));
          jump_addr = 4'($urandom_range(0, 15));
          step();
          n_vec++;
          if (!instr_valid || {opcode, operand} !== exp_b) begin
            n_err++;
            $display("FAIL random_hold: v=%b instr=%h, want v=1 instr=%h",
                     instr_valid, {opcode, operand}, exp_b);
          end
        end
        jmp = ($urandom_range(0, 3) == 0);
        ja = 4'($urandom_range(0, 15));
        do_ack(jmp, ja);
        if (exp_b[7:4] == 4'hF) begin
          n_vec++;
          if (halted !== 1 || pc !== model_pc + 4'd1 || rom_read_en !== 0) begin
            n_err++;
            $display("FAIL random_halt: h=%b pc=%h re=%b, want h=1 pc=%h re=0",
                     halted, pc, rom_read_en, model_pc + 4'd1);
          end
          break;
        end
        model_pc = jmp ? ja : model_pc + 4'd1;
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 16; i++) rom3[i] = 8'h00;
    rom3[0] = 8'h10;
    rst_n = 0;
    rst3_n = 0;
    step();
    rst3_n = 1;
    step();
    start = 1; step(); start = 0;   // first settle cycle
    step();                         // second settle cycle
    n_vec++;
    if (rom_read_en3 !== 1 || pc3 !== 4'h0) begin
      n_err++;
      $display("FAIL async_pre: re=%b pc=%h, want re=1 pc=0", rom_read_en3, pc3);
    end
    rst3_n = 0;
    #1;
    n_vec++;
    if (rom_read_en3 !== 0 || pc3 !== 4'h0 || {opcode3, operand3} !== 8'h00 || dbg_state3 !== 2'd0) begin
      n_err++;
      $display("FAIL async_reset: re=%b pc=%h instr=%h st=%0d, want 0 0 00 IDLE",
               rom_read_en3, pc3, {opcode3, operand3}, dbg_state3);
    end
    step();
    rst3_n = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      n_vec++;
      if (rom_read_en3 !== 0 || instr_valid3 !== 0 || pc3 !== 4'h0 ||
          {opcode3, operand3} !== 8'h00 || dbg_state3 !== 2'd0) begin
        n_err++;
        $display("FAIL async_idle: cycle %0d re=%b v=%b pc=%h instr=%h st=%0d, want idle zeros",
                 i, rom_read_en3, instr_valid3, pc3, {opcode3, operand3}, dbg_state3);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    for (int i = 0; i < 16; i++) begin rom[i] = 8'h00; rom3[i] = 8'h00; end
    step();
    test_reset();
    test_free_run();
    test_backpressure();
    test_jump();
    test_wrap();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
